mips_mem_bridge: RTL and testbench
==================================

Name: mips_mem_bridge

Overview:
- Avalon memory-mapped master sitting between the MIPS CPU core and the Avalon RAM slave.
- Arbitrates the core's instruction-fetch port and data port onto one Avalon bus.
- Holds address, writedata and byteenable stable for the whole waitrequest window.
- Returns read data and one-cycle completion strobes to the requesting side.

Parameters:
- RESET_VECTOR, 32'hBFC00000: value av_address takes in reset and idle.
- TIMEOUT_CYCLES, 64: waitrequest cycles tolerated before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  instruction fetch request, held high until i_done
- i_addr  in  32  fetch byte address
- i_rdata  out  32  fetched word, valid while i_done=1
- i_done  out  1  one-cycle fetch completion strobe
- d_read  in  1  data read request, held until d_done
- d_write  in  1  data write request, held until d_done
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_byteen  in  4  write byte enables
- d_rdata  out  32  read word, valid while d_done=1
- d_done  out  1  one-cycle data completion strobe
- err  out  1  pulses with a done strobe when the request was rejected or aborted
- busy  out  1  high in any non-IDLE state
- av_address  out  32  Avalon address
- av_read  out  1  Avalon read
- av_write  out  1  Avalon write
- av_writedata  out  32  Avalon writedata
- av_byteenable  out  4  Avalon byteenable
- av_waitrequest  in  1  Avalon waitrequest
- av_readdata  in  32  Avalon readdata
- timeout  out  1  sticky abort flag (optional feature)

Behaviour:
- Reset (async, active-high) sets:
  - state=IDLE
  - av_read=av_write=0, av_address=RESET_VECTOR, av_writedata=0, av_byteenable=0
  - i_done=d_done=err=busy=0, i_rdata=d_rdata=0, timeout=0
  - last_grant=INSTR
- All outputs are registered.
- States:
  - IDLE: evaluate requests at each posedge.
  - IFETCH, DREAD, DWRITE: Avalon transaction in flight.
  - DONE: one cycle; the done strobe is high and no new grant is made. This gives the client time to drop its request.
- Arbitration in IDLE:
  - Pending sources are i_req and (d_read|d_write).
  - If only one is pending, grant it.
  - If both are pending, grant the one not in last_grant. Data therefore wins the first conflict after reset, and the two alternate thereafter.
  - last_grant updates on every grant.
- Grant:
  - Latch address, writedata and byteenable.
  - Drive av_read or av_write from the next cycle.
  - Reads drive av_byteenable=4'hF.
  - Fetches always read.
- Rejection, checked at grant:
  - Triggers: addr[1:0]!=0, or d_read&d_write both high.
  - No Avalon transaction is issued.
  - Go to DONE with the matching done strobe and err=1; rdata is unchanged.
- Completion:
  - At the posedge where (av_read|av_write)&&!av_waitrequest, deassert av_read/av_write.
  - For reads, capture av_readdata into i_rdata or d_rdata.
  - Enter DONE; the done strobe is high the following cycle.
- Latency:
  - Request sampled at edge 0, av strobe high in cycle 1, done high in cycle 2 when waitrequest=0.
  - Each waitrequest cycle adds 1, so latency is N+2 cycles for N wait cycles.
- Stability:
  - av_address, av_writedata and av_byteenable do not change while av_read or av_write is high.
  - av_read and av_write are never high together.
- Idle: av_address returns to RESET_VECTOR; av_writedata and av_byteenable hold their last values.
- Reset mid-transaction: strobes drop immediately (async), no done strobe is issued, and the client re-requests.
- Client dropping a request mid-transaction is ignored; the transaction completes and the done strobe still fires.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter increments each cycle waitrequest is high during a transaction.
  - On reaching TIMEOUT_CYCLES, abort: drop the strobe, go to DONE, pulse the done strobe with err=1, and set timeout=1 (sticky until reset).
  - The counter clears at each grant.
- MEM_TIMEOUT_EN undefined: waits indefinitely and timeout is tied 0.

Test Plan:
- Fetch i_addr=0xBFC00000 with slave waitrequest for 2 cycles returning 0x24020005 -> av_read high for 3 cycles with constant address, i_done in cycle 4, i_rdata=0x24020005, err=0.
- Write d_addr=0x10, d_wdata=0xDEADBEEF, d_byteen=4'b0011, zero-wait slave -> one av_write cycle with exact values, d_done in cycle 2; a read of 0x10 then returns the merged word.
- i_req and d_read raised in the same cycle after reset, both held -> data granted first, fetch granted directly after its DONE; the next conflict grants fetch first.
- d_read with d_addr=0x12 -> no av_read, d_done=1 with err=1 two cycles later. d_read&d_write both high -> same response.
- Reset asserted while av_write is high -> av_write=0 asynchronously, no d_done, busy=0.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4 and waitrequest stuck high -> strobe dropped after 4 wait cycles, done+err pulse, timeout=1 until reset.

Source files
------------

// File: rtl/mips_mem_bridge.sv
// mips_mem_bridge
//   Avalon-MM master that connects the MIPS core's instruction-fetch and data ports to a
//   single Avalon RAM slave. Only one transaction is in flight at a time. Address, writedata
//   and byteenable stay constant while a strobe is high. Each request is answered with a
//   one-cycle done strobe and, for reads, the captured word.
//
//   Ports
//     clk, reset        system clock (rising edge), asynchronous active-high reset
//     i_req, i_addr     fetch request and byte address; held until i_done
//     i_rdata, i_done   fetched word and one-cycle completion strobe
//     d_read, d_write   data request (held until d_done), d_addr, d_wdata, d_byteen
//     d_rdata, d_done   read word and one-cycle completion strobe
//     err               high together with a done strobe for a rejected or aborted request
//     busy              high whenever the bridge is not idle
//     av_*              Avalon-MM master signals
//     timeout           sticky abort flag
//
//   Build option: define MEM_TIMEOUT_EN to abort a transaction after TIMEOUT_CYCLES
//   waitrequest cycles. Without it the bridge waits indefinitely and timeout is tied low.
module mips_mem_bridge #(
   parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_done,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_byteen,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        err,
   output logic        busy,
   output logic [31:0] av_address,
   output logic        av_read,
   output logic        av_write,
   output logic [31:0] av_writedata,
   output logic [3:0]  av_byteenable,
   input  logic        av_waitrequest,
   input  logic [31:0] av_readdata,
   output logic        timeout
);

   // StReject is the bus-idle cycle of a rejected request, so a reject is answered with the
   // same latency as a zero-wait access.
   typedef enum logic [2:0] {StIdle, StIfetch, StDread, StDwrite, StReject, StDone} state_e;

   state_e      state_q, state_d;
   logic        last_grant_q, last_grant_d;  // 1: data port got the last grant
   logic [31:0] addr_q, addr_d;
   logic        read_q, read_d;
   logic        write_q, write_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        i_done_q, i_done_d;
   logic        d_done_q, d_done_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;

   logic        i_pend, d_pend, grant_data, i_bad, d_bad;
   logic        xfer;
   logic        abort;

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("mips_mem_bridge: TIMEOUT_CYCLES must be nonzero");
   end

   assign xfer = (state_q == StIfetch) || (state_q == StDread) || (state_q == StDwrite);

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
   logic            timeout_q, timeout_d;

   // The abort fires on the edge that would complete the TIMEOUT_CYCLES-th wait cycle.
   assign abort = xfer && av_waitrequest && (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      if (state_q == StIdle) begin
         wait_cnt_d = '0;
      end else if (xfer && av_waitrequest) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
      if (abort) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign abort   = 1'b0;
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      read_d       = read_q;
      write_d      = write_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      i_done_d     = 1'b0;
      d_done_d     = 1'b0;
      err_d        = 1'b0;

      i_pend     = i_req;
      d_pend     = d_read | d_write;
      // On a conflict the side that did not win last time gets the bus.
      grant_data = d_pend && (!i_pend || !last_grant_q);
      i_bad      = (i_addr[1:0] != 2'b00);
      d_bad      = (d_addr[1:0] != 2'b00) || (d_read && d_write);

      unique case (state_q)
         StIdle: begin
            if (i_pend || d_pend) begin
               last_grant_d = grant_data;
               if (grant_data ? d_bad : i_bad) begin
                  state_d = StReject;
               end else if (grant_data) begin
                  addr_d = d_addr;
                  if (d_write) begin
                     state_d = StDwrite;
                     write_d = 1'b1;
                     wdata_d = d_wdata;
                     be_d    = d_byteen;
                  end else begin
                     state_d = StDread;
                     read_d  = 1'b1;
                     be_d    = 4'hF;
                  end
               end else begin
                  state_d = StIfetch;
                  read_d  = 1'b1;
                  addr_d  = i_addr;
                  be_d    = 4'hF;
               end
            end
         end
         StIfetch, StDread, StDwrite: begin
            if (!av_waitrequest || abort) begin
               state_d = StDone;
               read_d  = 1'b0;
               write_d = 1'b0;
               addr_d  = RESET_VECTOR;
               err_d   = abort;
               if (state_q == StIfetch) begin
                  i_done_d = 1'b1;
                  if (!abort) begin
                     i_rdata_d = av_readdata;
                  end
               end else begin
                  d_done_d = 1'b1;
                  if ((state_q == StDread) && !abort) begin
                     d_rdata_d = av_readdata;
                  end
               end
            end
         end
         StReject: begin
            state_d = StDone;
            err_d   = 1'b1;
            if (last_grant_q) begin
               d_done_d = 1'b1;
            end else begin
               i_done_d = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b0;
         addr_q       <= RESET_VECTOR;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         wdata_q      <= '0;
         be_q         <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         i_done_q     <= 1'b0;
         d_done_q     <= 1'b0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         read_q       <= read_d;
         write_q      <= write_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         i_done_q     <= i_done_d;
         d_done_q     <= d_done_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
      end
   end

   assign av_address    = addr_q;
   assign av_read       = read_q;
   assign av_write      = write_q;
   assign av_writedata  = wdata_q;
   assign av_byteenable = be_q;
   assign i_rdata       = i_rdata_q;
   assign d_rdata       = d_rdata_q;
   assign i_done        = i_done_q;
   assign d_done        = d_done_q;
   assign err           = err_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_mips_mem_bridge.sv
module tb_mips_mem_bridge;

   localparam logic [31:0] RV = 32'hBFC00000;
   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_done;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_byteen;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        err;
   logic        busy;
   logic [31:0] av_address;
   logic        av_read;
   logic        av_write;
   logic [31:0] av_writedata;
   logic [3:0]  av_byteenable;
   logic        av_waitrequest = 1'b0;
   logic [31:0] av_readdata = '0;
   logic        timeout;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mips_mem_bridge #(.RESET_VECTOR(RV), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_byteen(d_byteen), .d_rdata(d_rdata), .d_done(d_done),
      .err(err), .busy(busy),
      .av_address(av_address), .av_read(av_read), .av_write(av_write),
      .av_writedata(av_writedata), .av_byteenable(av_byteenable),
      .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
      .timeout(timeout)
   );

   // Contents of a word nobody has written yet.
   function automatic logic [31:0] init_word(input int unsigned w);
      return (w * 32'h9E3779B1) ^ 32'h5A5AC3C3;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // ---------------- Avalon slave (environment) ----------------
   logic [31:0] slv_mem [int unsigned];
   int unsigned next_waits = 0;
   int unsigned wait_left = 0;
   int unsigned slv_w;
   logic [31:0] slv_cur;

   always @(negedge clk) begin
      if (av_read || av_write) begin
         if (wait_left > 0) begin
            av_waitrequest = 1'b1;
            wait_left--;
            av_readdata = $urandom;
         end else begin
            av_waitrequest = 1'b0;
            slv_w = int'(av_address[31:2]);
            slv_cur = slv_mem.exists(slv_w) ? slv_mem[slv_w] : init_word(slv_w);
            if (av_write) slv_mem[slv_w] = merge(slv_cur, av_writedata, av_byteenable);
            av_readdata = av_read ? slv_cur : $urandom;
         end
      end else begin
         av_waitrequest = 1'($urandom_range(0, 1));
         wait_left = next_waits;
         av_readdata = $urandom;
      end
   end

   // ---------------- Bus protocol monitor ----------------
   logic        prev_strobe = 1'b0;
   logic [31:0] prev_addr, prev_wdata;
   logic [3:0]  prev_be;

   always @(negedge clk) begin
      if (!reset) begin
         checks++;
         assert (!(av_read && av_write)) else begin
            failures++;
            $error("FAIL rw_exclusive observed read=%0b write=%0b expected=not both", av_read,
                   av_write);
         end
         if (prev_strobe && (av_read || av_write)) begin
            checks++;
            assert ({av_address, av_writedata, av_byteenable} ===
                    {prev_addr, prev_wdata, prev_be}) else begin
               failures++;
               $error("FAIL bus_stable observed=%h/%h/%h expected=%h/%h/%h", av_address,
                      av_writedata, av_byteenable, prev_addr, prev_wdata, prev_be);
            end
         end
      end
      prev_strobe = !reset && (av_read || av_write);
      prev_addr   = av_address;
      prev_wdata  = av_writedata;
      prev_be     = av_byteenable;
   end

   // ---------------- Reference model ----------------
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] exp_i_rdata = '0;
   logic [31:0] exp_d_rdata = '0;
   logic        exp_timeout = 1'b0;

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      int unsigned w;
      w = int'(a[31:2]);
      return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // kind: 0 fetch, 1 data read, 2 data write, 3 read+write together.
   // Called #1 after a posedge with the bridge idle; returns #1 after the post-DONE edge.
   task automatic xfer(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int unsigned waits);
      bit          rej, abrt, seen, i_d, d_d, e_d;
      int          exp_lat, exp_strobes, k, strobes;
      logic [31:0] ir, dr;
      rej  = (addr[1:0] != 2'b00) || (kind == 3);
      abrt = 1'b0;
`ifdef MEM_TIMEOUT_EN
      if (!rej && waits >= TO) abrt = 1'b1;
`endif
      exp_lat     = rej ? 2 : (abrt ? int'(TO) + 1 : int'(waits) + 2);
      exp_strobes = rej ? 0 : (abrt ? int'(TO) : int'(waits) + 1);
      next_waits  = waits;
      if (kind == 0) begin
         i_req = 1'b1;
         i_addr = addr;
      end else begin
         d_read   = (kind == 1) || (kind == 3);
         d_write  = (kind == 2) || (kind == 3);
         d_addr   = addr;
         d_wdata  = wdata;
         d_byteen = be;
      end
      strobes = 0; seen = 1'b0; k = 0; i_d = 0; d_d = 0; e_d = 0; ir = '0; dr = '0;
      while (!seen && k < exp_lat + 8) begin
         @(posedge clk); #1;
         k++;
         if (av_read || av_write) begin
            strobes++;
            if (strobes == 1) begin
               chk("av_read", 32'(av_read), 32'(kind != 2));
               chk("av_write", 32'(av_write), 32'(kind == 2));
               chk("av_address", av_address, addr);
               chk("av_byteenable", 32'(av_byteenable), (kind == 2) ? 32'(be) : 32'hF);
               if (kind == 2) chk("av_writedata", av_writedata, wdata);
            end
         end
         if (i_done || d_done) begin
            seen = 1'b1; i_d = i_done; d_d = d_done; e_d = err; ir = i_rdata; dr = d_rdata;
         end
      end
      i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
      if (!rej && !abrt) begin
         if (kind == 0) exp_i_rdata = ref_rd(addr);
         if (kind == 1) exp_d_rdata = ref_rd(addr);
         if (kind == 2) ref_mem[int'(addr[31:2])] = merge(ref_rd(addr), wdata, be);
      end
      if (abrt) exp_timeout = 1'b1;
      chk("done_seen", 32'(seen), 32'd1);
      chk("latency", k, exp_lat);
      chk("strobe_cycles", strobes, exp_strobes);
      chk("i_done", 32'(i_d), 32'(kind == 0));
      chk("d_done", 32'(d_d), 32'(kind != 0));
      chk("err", 32'(e_d), 32'(rej || abrt));
      chk("i_rdata", ir, exp_i_rdata);
      chk("d_rdata", dr, exp_d_rdata);
      @(posedge clk); #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_dones", {30'd0, i_done, d_done}, 32'd0);
      chk("idle_address", av_address, RV);
      chk("timeout", 32'(timeout), 32'(exp_timeout));
   endtask

   initial begin : main
      int          k, n;
      byte         order [3];
      int          when [3];
      byte         exp_order [3];
      int          exp_when [3];
      int          kind, pick;
      logic [31:0] a;

      reset = 1'b1; i_req = 0; i_addr = '0; d_read = 0; d_write = 0;
      d_addr = '0; d_wdata = '0; d_byteen = '0;
      #1;
      chk("rst_av_address", av_address, RV);
      chk("rst_strobes", {30'd0, av_read, av_write}, 32'd0);
      chk("rst_av_writedata", av_writedata, 32'd0);
      chk("rst_av_byteenable", 32'(av_byteenable), 32'd0);
      chk("rst_flags", {27'd0, i_done, d_done, err, busy, timeout}, 32'd0);
      chk("rst_i_rdata", i_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;

      // First conflict after reset: data, then fetch, then the re-requesting data port.
      exp_order = '{8'h44, 8'h49, 8'h44};
      exp_when  = '{2, 5, 8};
      next_waits = 0;
      i_req = 1'b1; i_addr = 32'h100; d_read = 1'b1; d_addr = 32'h104;
      k = 0; n = 0;
      while (n < 3 && k < 20) begin
         @(posedge clk); #1;
         k++;
         if (d_done) begin
            exp_d_rdata = ref_rd(d_addr);
            chk("arb_d_rdata", d_rdata, exp_d_rdata);
            order[n] = 8'h44; when[n] = k; n++;
            if (n == 1) d_addr = 32'h108;
            else d_read = 1'b0;
         end
         if (i_done) begin
            exp_i_rdata = ref_rd(i_addr);
            chk("arb_i_rdata", i_rdata, exp_i_rdata);
            order[n] = 8'h49; when[n] = k; n++;
            i_req = 1'b0;
         end
      end
      i_req = 1'b0; d_read = 1'b0;
      chk("arb_count", n, 3);
      for (int j = 0; j < 3; j++) begin
         chk("arb_order", 32'(order[j]), 32'(exp_order[j]));
         chk("arb_cycle", when[j], exp_when[j]);
      end
      @(posedge clk); #1;

      // Directed cases.
      slv_mem[int'(RV[31:2])] = 32'h24020005;
      ref_mem[int'(RV[31:2])] = 32'h24020005;
      xfer(0, RV, 32'h0, 4'h0, 2);
      chk("fetch_word", exp_i_rdata, 32'h24020005);
      xfer(2, 32'h10, 32'hDEADBEEF, 4'b0011, 0);
      xfer(1, 32'h10, 32'h0, 4'h0, 0);
      xfer(1, 32'h12, 32'h0, 4'h0, 0);
      xfer(3, 32'h20, 32'h12345678, 4'hF, 0);
      xfer(0, 32'h6, 32'h0, 4'h0, 1);

`ifdef MEM_TIMEOUT_EN
      xfer(1, 32'h30, 32'h0, 4'h0, 50);
      xfer(0, 32'h34, 32'h0, 4'h0, 0);
`endif

      // Randomized traffic over a small pool of words so reads hit earlier writes.
      for (int t = 0; t < 40; t++) begin
         pick = $urandom_range(0, 9);
         kind = (pick < 3) ? 0 : (pick < 6) ? 1 : (pick < 9) ? 2 : 3;
         a = 32'h200 + 32'($urandom_range(0, 7)) * 4;
         if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
         xfer(kind, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 5));
      end

      // Reset in the middle of a write: strobe drops at once, no done strobe.
      next_waits = 20;
      d_write = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFEF00D; d_byteen = 4'hF;
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk("pre_reset_write", 32'(av_write), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_write_drop", 32'(av_write), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_done", {30'd0, i_done, d_done}, 32'd0);
      chk("async_timeout", 32'(timeout), 32'd0);
      d_write = 1'b0;
      exp_timeout = 1'b0;
      exp_i_rdata = '0;
      exp_d_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_done", {30'd0, i_done, d_done}, 32'd0);
      xfer(1, 32'h40, 32'h0, 4'h0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
